uart_time_parser: RTL and testbench

//  Parses the network-time reply coming from the UART receiver of the internet time-set path.

---
 rtl/uart_time_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_time_parser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_parser.sv
`timescale 1ns/1ps
// Parses "$YYYYMMDDhhmmss<CR|LF>" from a UART byte stream into BCD date/time
// with a one-cycle load strobe, or an error strobe with a cause code.
module uart_time_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        busy,
  output logic [15:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  minute_bcd,
  output logic [7:0]  second_bcd,
  output logic        time_valid,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CH_SOF = 8'h24;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  localparam logic [1:0] ERR_CHAR  = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_DIGITS   = 3'd2,
    S_WAIT_EOL = 3'd3,
    S_CHECK    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_dcnt;
  logic [55:0]       r_shift;
  logic              r_busy;
  logic [55:0]       r_time;
  logic              r_time_valid;
  logic              r_error;
  logic [1:0]        r_err_code;

  logic              w_arm;
  logic              w_shift_en;
  logic              w_dclr;
  logic              w_load;
  logic              w_err;
  logic [1:0]        w_err_code;
  logic              w_is_digit;
  logic              w_is_sof;
  logic              w_is_eol;
  logic              w_tmo;
  logic              w_range_ok;

  // BCD compare is order-preserving once every nibble is a decimal digit.
  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic fields_ok(input logic [55:0] f);
    return in_range(f[39:32], 8'h01, 8'h12) && in_range(f[31:24], 8'h01, 8'h31) &&
           in_range(f[23:16], 8'h00, 8'h23) && in_range(f[15:8],  8'h00, 8'h59) &&
           in_range(f[7:0],   8'h00, 8'h59);
  endfunction

  assign w_is_digit = rx_valid && (rx_data >= CH_0) && (rx_data <= CH_9);
  assign w_is_sof   = rx_valid && (rx_data == CH_SOF);
  assign w_is_eol   = rx_valid && ((rx_data == CH_CR) || (rx_data == CH_LF));
  assign w_tmo      = (r_cnt == CNT_LAST);
  assign w_range_ok = fields_ok(r_shift);

  // Next-state and strobe decisions
  always_comb begin
    w_next     = r_state;
    w_arm      = 1'b0;
    w_shift_en = 1'b0;
    w_dclr     = 1'b0;
    w_load     = 1'b0;
    w_err      = 1'b0;
    w_err_code = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_WAIT_SOF;
          w_arm  = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_SOF: begin
        if (w_tmo) begin
          w_next     = S_IDLE;
          w_err      = 1'b1;
          w_err_code = ERR_TMO;
        end else if (w_is_sof) begin
          w_next = S_DIGITS;
          w_dclr = 1'b1;
        end else begin
          w_next = S_WAIT_SOF;
        end
      end
      S_DIGITS: begin
        if (w_tmo) begin
          w_next     = S_IDLE;
          w_err      = 1'b1;
          w_err_code = ERR_TMO;
        end else if (w_is_digit) begin
          w_shift_en = 1'b1;
          w_next     = (r_dcnt == 4'd13) ? S_WAIT_EOL : S_DIGITS;
        end else if (w_is_sof) begin
          w_dclr = 1'b1;
        end else if (rx_valid) begin
          w_next     = S_IDLE;
          w_err      = 1'b1;
          w_err_code = ERR_CHAR;
        end else begin
          w_next = S_DIGITS;
        end
      end
      S_WAIT_EOL: begin
        // A terminator in the timeout cycle still completes the frame.
        if (w_is_eol) begin
          w_next = S_CHECK;
        end else if (w_tmo) begin
          w_next     = S_IDLE;
          w_err      = 1'b1;
          w_err_code = ERR_TMO;
        end else if (rx_valid) begin
          w_next     = S_IDLE;
          w_err      = 1'b1;
          w_err_code = ERR_CHAR;
        end else begin
          w_next = S_WAIT_EOL;
        end
      end
      S_CHECK: begin
        w_next = S_IDLE;
        if (w_range_ok) begin
          w_load = 1'b1;
        end else begin
          w_err      = 1'b1;
          w_err_code = ERR_RANGE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame timer, digit counter and digit shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_dcnt  <= 4'd0;
      r_shift <= 56'h0;
    end else begin
      if (w_arm) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT_SOF) || (r_state == S_DIGITS) ||
                   (r_state == S_WAIT_EOL)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_arm || w_dclr) begin
        r_dcnt <= 4'd0;
      end else if (w_shift_en) begin
        r_dcnt <= r_dcnt + 4'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_shift[51:0], rx_data[3:0]};
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= 1'b0;
      r_time       <= 56'h20000101000000;
      r_time_valid <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_busy       <= (w_next != S_IDLE);
      r_time_valid <= w_load;
      r_error      <= w_err;
      if (w_load) begin
        r_time <= r_shift;
      end
      if (w_err) begin
        r_err_code <= w_err_code;
      end
    end
  end

  assign busy       = r_busy;
  assign year_bcd   = r_time[55:40];
  assign month_bcd  = r_time[39:32];
  assign day_bcd    = r_time[31:24];
  assign hour_bcd   = r_time[23:16];
  assign minute_bcd = r_time[15:8];
  assign second_bcd = r_time[7:0];
  assign time_valid = r_time_valid;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_uart_time_parser.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for uart_time_parser: stimulus builds frames from
// integer date/time fields and queues the expected strobe; a monitor checks it.
module tb_uart_time_parser;

  localparam int TMO = 100;
  localparam logic [55:0] DEF_TIME = 56'h20000101000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        busy, time_valid, error;
  logic [1:0]  err_code;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;

  uart_time_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .time_valid(time_valid), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [55:0] bcd;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [55:0] exp_out = DEF_TIME;
  logic [1:0]  exp_code = 2'b00;
  logic [7:0]  frm[$];
  int          gap_max = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [55:0] outs();
    return {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_strobe: no strobe by cycle %0d", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (time_valid || error) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: time_valid=%0b error=%0b at cycle %0d, expected none",
                   time_valid, error, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", 64'({time_valid, error}), e.is_err ? 64'd1 : 64'd2);
          check("strobe_cycle", 64'(cyc), 64'(e.cyc));
          check("busy_at_strobe", 64'(busy), 64'd0);
          if (e.is_err) begin
            check("err_code", 64'(err_code), 64'(e.code));
            check("hold_on_error", 64'(outs()), 64'(exp_out));
            exp_code = e.code;
          end else begin
            check("time_out", 64'(outs()), 64'(e.bcd));
            exp_out = e.bcd;
          end
        end
      end else begin
        check("hold", 64'({outs(), err_code}), 64'({exp_out, exp_code}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_start(output int ts);
    start = 1'b1;
    tick();
    ts = cyc;
    start = 1'b0;
  endtask

  task automatic push_num(input int v, input int n);
    int p;
    p = 1;
    for (int i = 1; i < n; i++) p = p * 10;
    for (int i = 0; i < n; i++) begin
      frm.push_back(8'(32'h30 + (v / p) % 10));
      p = p / 10;
    end
  endtask

  task automatic push_time(input int y, input int mo, input int d, input int h,
                           input int mi, input int s);
    push_num(y, 4); push_num(mo, 2); push_num(d, 2);
    push_num(h, 2); push_num(mi, 2); push_num(s, 2);
  endtask

  function automatic logic [55:0] bcd_of(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
    logic [55:0] r;
    r[55:52] = 4'(y / 1000);      r[51:48] = 4'((y / 100) % 10);
    r[47:44] = 4'((y / 10) % 10); r[43:40] = 4'(y % 10);
    r[39:36] = 4'(mo / 10);       r[35:32] = 4'(mo % 10);
    r[31:28] = 4'(d / 10);        r[27:24] = 4'(d % 10);
    r[23:20] = 4'(h / 10);        r[19:16] = 4'(h % 10);
    r[15:12] = 4'(mi / 10);       r[11:8]  = 4'(mi % 10);
    r[7:4]   = 4'(s / 10);        r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  // Sends frm; the byte at ev_idx schedules one strobe, off cycles after its consumption.
  task automatic send_frame(input int ev_idx, input bit is_err, input logic [1:0] code,
                            input logic [55:0] bcd, input int off);
    exp_t e;
    for (int i = 0; i < frm.size(); i++) begin
      if (i == ev_idx) begin
        e.is_err = is_err;
        e.code   = code;
        e.bcd    = bcd;
        e.cyc    = cyc + 1 + off;
        exp_q.push_back(e);
      end
      send(frm[i]);
      idle($urandom_range(0, gap_max));
    end
    frm.delete();
  endtask

  logic [7:0] bad_tab[5] = '{8'h41, 8'h20, 8'h3A, 8'h2F, 8'hFF};

  initial begin
    int ts, kind, f, pos, y, mo, d, h, mi, s;
    logic [7:0] term;
    exp_t e;

    idle(3);
    reset_n = 1'b1;
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_strobes", 64'({time_valid, error, err_code}), 64'd0);
    check("reset_time", 64'(outs()), 64'(DEF_TIME));

    // 1: nominal frame terminated by CR
    pulse_start(ts);
    check("busy_after_start", 64'(busy), 64'd1);
    frm.push_back(8'h24); push_time(2024, 9, 11, 21, 30, 5); frm.push_back(8'h0D);
    send_frame(frm.size() - 1, 1'b0, 2'b00, 56'h20240911213005, 1);
    idle(3);

    // 2: month 13 -> range error, outputs hold
    pulse_start(ts);
    frm.push_back(8'h24); push_time(2024, 13, 1, 0, 0, 0); frm.push_back(8'h0A);
    send_frame(frm.size() - 1, 1'b1, 2'b10, 56'h0, 1);
    idle(3);

    // 3: garbage, partial frame, resync on second '$'
    pulse_start(ts);
    frm.push_back(8'h78); frm.push_back(8'h78); frm.push_back(8'h24); push_num(2024, 4);
    frm.push_back(8'h24); push_time(2025, 1, 1, 23, 59, 59); frm.push_back(8'h0D);
    send_frame(frm.size() - 1, 1'b0, 2'b00, 56'h20250101235959, 1);
    idle(3);

    // 4: bad character inside the digits
    pulse_start(ts);
    frm.push_back(8'h24); push_num(2024, 4); frm.push_back(8'h41);
    send_frame(5, 1'b1, 2'b01, 56'h0, 0);
    idle(1);

    // 5a: timeout with no bytes; a second start while busy is ignored
    pulse_start(ts);
    e.is_err = 1'b1; e.code = 2'b11; e.bcd = 56'h0; e.cyc = ts + TMO;
    exp_q.push_back(e);
    while (cyc < ts + 49) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < ts + TMO + 4) tick();

    // 5b: terminator lands in the last timeout cycle and wins
    pulse_start(ts);
    frm.push_back(8'h24); push_time(2031, 12, 31, 23, 59, 58);
    send_frame(-1, 1'b0, 2'b00, 56'h0, 0);
    while (cyc < ts + TMO - 1) tick();
    frm.push_back(8'h0D);
    send_frame(0, 1'b0, 2'b00, 56'h20311231235958, 1);
    idle(3);

    // 6: reset mid-frame, then a frame without start must be ignored
    pulse_start(ts);
    frm.push_back(8'h24); push_num(2099123, 7);
    send_frame(-1, 1'b0, 2'b00, 56'h0, 0);
    reset_n = 1'b0;
    exp_q.delete();
    exp_out = DEF_TIME;
    exp_code = 2'b00;
    #1;
    check("reset_mid_busy", 64'(busy), 64'd0);
    check("reset_mid_time", 64'({outs(), err_code}), 64'({DEF_TIME, 2'b00}));
    idle(2);
    reset_n = 1'b1;
    tick();
    frm.push_back(8'h24); push_time(2024, 9, 11, 21, 30, 5); frm.push_back(8'h0D);
    send_frame(-1, 1'b0, 2'b00, 56'h0, 0);
    idle(5);
    check("no_start_time", 64'(outs()), 64'(DEF_TIME));

    // Randomized frames
    gap_max = 2;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      y = $urandom_range(0, 9999); mo = $urandom_range(1, 12); d = $urandom_range(1, 31);
      h = $urandom_range(0, 23);   mi = $urandom_range(0, 59); s = $urandom_range(0, 59);
      term = ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A;
      pulse_start(ts);
      if (kind == 1) begin
        f = $urandom_range(0, 4);
        case (f)
          0: mo = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(13, 99);
          1: d  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(32, 99);
          2: h  = $urandom_range(24, 99);
          3: mi = $urandom_range(60, 99);
          default: s = $urandom_range(60, 99);
        endcase
        frm.push_back(8'h24); push_time(y, mo, d, h, mi, s); frm.push_back(term);
        send_frame(frm.size() - 1, 1'b1, 2'b10, 56'h0, 1);
      end else if (kind == 2) begin
        pos = $urandom_range(0, 14);
        frm.push_back(8'h24); push_time(y, mo, d, h, mi, s);
        while (frm.size() > pos + 1) void'(frm.pop_back());
        frm.push_back(bad_tab[$urandom_range(0, 4)]);
        send_frame(pos + 1, 1'b1, 2'b01, 56'h0, 0);
      end else begin
        if (kind == 3) begin
          repeat ($urandom_range(0, 2)) begin
            term = 8'($urandom_range(0, 255));
            frm.push_back((term == 8'h24) ? 8'h25 : term);
          end
          frm.push_back(8'h24);
          repeat ($urandom_range(0, 5)) push_num($urandom_range(0, 9), 1);
          term = ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A;
        end
        frm.push_back(8'h24); push_time(y, mo, d, h, mi, s); frm.push_back(term);
        send_frame(frm.size() - 1, 1'b0, 2'b00, bcd_of(y, mo, d, h, mi, s), 1);
      end
      idle(3);
    end

    idle(5);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
